// File: rtl/pqsdn_tbl_pkg.sv
// Shared definitions for the pqsdn table access controller.
package pqsdn_tbl_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_CLEAR = 2'd2,
      ST_DRAIN = 2'd3
   } tbl_state_e;

   // Edges between a RAM write being presented and becoming readable.
   localparam int RAM_WR_LAT = 2;
   // Quiet cycles after the last clear write before declaring done.
   localparam int DRAIN_CYC  = 2;
   // Number of write-forwarding stages (this cycle + last cycle).
   localparam int FWD_DEPTH  = 2;

endpackage

// File: rtl/pqsdn_rsp_fifo.sv
// First-word fall-through sync FIFO carrying {data, tag} lookup responses.
module pqsdn_rsp_fifo #(
   parameter int W     = 72,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_i,
   input  logic [W-1:0]              din_i,
   input  logic                      pop_i,
   output logic                      valid_o,
   output logic [W-1:0]              dout_o,
   output logic [$clog2(DEPTH):0]    count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          pop_ok;

   // A pop on an empty FIFO is dropped; push while full only ever comes with a pop.
   assign pop_ok  = pop_i && (cnt_q != '0);
   assign valid_o = (cnt_q != '0);
   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop_ok) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_ok);
      end
   end

endmodule

// File: rtl/pqsdn_tbl_ctrl.sv
// Access controller in front of pqsdn_ram: updates, forwarded lookups, clear engine.
module pqsdn_tbl_ctrl
   import pqsdn_tbl_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 10,
   parameter int TAG_W      = 8,
   parameter int RSP_DEPTH  = 4,
   parameter bit CLR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_start_i,
   output logic              clr_busy_o,
   output logic              clr_done_o,
   input  logic              upd_valid_i,
   output logic              upd_ready_o,
   input  logic [ADDR_W-1:0] upd_addr_i,
   input  logic [DATA_W-1:0] upd_data_i,
   input  logic              lkp_valid_i,
   output logic              lkp_ready_o,
   input  logic [ADDR_W-1:0] lkp_addr_i,
   input  logic [TAG_W-1:0]  lkp_tag_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic [TAG_W-1:0]  rsp_tag_o,
   output logic              ram_en_o,
   output logic [ADDR_W-1:0] ram_wraddr_o,
   output logic [DATA_W-1:0] ram_wrdata_o,
   output logic              ram_rden_o,
   output logic [ADDR_W-1:0] ram_rdaddr_o,
   input  logic [DATA_W-1:0] ram_rddata_i
);

   localparam int              CW         = $clog2(RSP_DEPTH) + 1;
   localparam int              DCW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(DRAIN_CYC - 1);
   localparam logic [CW:0]     CREDITS    = (CW+1)'(RSP_DEPTH);

   tbl_state_e        state_q;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic [DCW-1:0]    drn_cnt_q;
   logic              busy_q, done_q;

   logic              idle, in_clear, upd_fire, lkp_fire;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              fwd1_vld_q;
   logic [ADDR_W-1:0] fwd1_addr_q;
   logic [DATA_W-1:0] fwd1_data_q;
   logic              hit0, hit1;
   logic              inflight_q, sel_fwd_q;
   logic [DATA_W-1:0] fwd_data_q;
   logic [TAG_W-1:0]  tag_q;
   logic [CW-1:0]     fifo_cnt;
   logic [CW:0]       occ;
   logic [DATA_W+TAG_W-1:0] fifo_din, fifo_dout;

   // Requests are only taken in IDLE, which also keeps ready low during INIT reset.
   assign idle        = (state_q == ST_IDLE);
   assign in_clear    = (state_q == ST_CLEAR);
   assign upd_ready_o = idle;
   assign upd_fire    = upd_valid_i && idle;
   assign occ         = (CW+1)'(fifo_cnt) + (CW+1)'(inflight_q);
   assign lkp_ready_o = idle && (occ < CREDITS);
   assign lkp_fire    = lkp_valid_i && lkp_ready_o;

   // Port A mux: clear counter with zero data, else the accepted update (this is fwd0).
   always_comb begin
      wr_en   = in_clear || upd_fire;
      wr_addr = '0;
      wr_data = '0;
      if (in_clear) wr_addr = clr_cnt_q;
      else if (upd_fire) begin
         wr_addr = upd_addr_i;
         wr_data = upd_data_i;
      end
   end

   assign ram_en_o     = wr_en;
   assign ram_wraddr_o = wr_addr;
   assign ram_wrdata_o = wr_data;
   assign ram_rden_o   = lkp_fire;
   assign ram_rdaddr_o = lkp_fire ? lkp_addr_i : '0;

   // Writes the RAM read cannot yet see: this cycle's (fwd0) and last cycle's (fwd1).
   assign hit0 = wr_en && (wr_addr == lkp_addr_i);
   assign hit1 = fwd1_vld_q && (fwd1_addr_q == lkp_addr_i);

   // Clear FSM with registered busy/done outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_INIT;
         clr_cnt_q <= '0;
         drn_cnt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_INIT: begin
               clr_cnt_q <= '0;
               if (CLR_ON_RST) begin
                  state_q <= ST_CLEAR;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (clr_start_i) begin
                  state_q   <= ST_CLEAR;
                  busy_q    <= 1'b1;
                  clr_cnt_q <= '0;
               end
            end
            ST_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (clr_cnt_q == '1) begin
                  state_q   <= ST_DRAIN;
                  drn_cnt_q <= '0;
               end
            end
            ST_DRAIN: begin
               drn_cnt_q <= drn_cnt_q + 1'b1;
               if (drn_cnt_q == DRAIN_LAST) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   assign clr_busy_o = busy_q;
   assign clr_done_o = done_q;

   // Lookup stage: remember forward choice and tag while the RAM read completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd1_vld_q  <= 1'b0;
         fwd1_addr_q <= '0;
         fwd1_data_q <= '0;
         inflight_q  <= 1'b0;
         sel_fwd_q   <= 1'b0;
         fwd_data_q  <= '0;
         tag_q       <= '0;
      end else begin
         fwd1_vld_q  <= wr_en;
         fwd1_addr_q <= wr_addr;
         fwd1_data_q <= wr_data;
         inflight_q  <= lkp_fire;
         if (lkp_fire) begin
            sel_fwd_q  <= hit0 || hit1;
            fwd_data_q <= hit0 ? wr_data : fwd1_data_q;
            tag_q      <= lkp_tag_i;
         end
      end
   end

   assign fifo_din = {(sel_fwd_q ? fwd_data_q : ram_rddata_i), tag_q};

   pqsdn_rsp_fifo #(
      .W     (DATA_W + TAG_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (inflight_q),
      .din_i   (fifo_din),
      .pop_i   (rsp_ready_i),
      .valid_o (rsp_valid_o),
      .dout_o  (fifo_dout),
      .count_o (fifo_cnt)
   );

   assign rsp_data_o = fifo_dout[DATA_W+TAG_W-1:TAG_W];
   assign rsp_tag_o  = fifo_dout[TAG_W-1:0];

endmodule

// File: doc/pqsdn_tbl_ctrl.md
Name: pqsdn_tbl_ctrl

Overview:
- Access controller sitting directly upstream of pqsdn_ram.
- Owns both RAM ports: accepts table updates (write port A) and tagged lookups (read port B), and returns lookup results through a valid/ready response stream.
- Hides the RAM's 2-edge write latency by forwarding in-flight writes to lookups.
- Provides a table-clear engine, run automatically after reset and on command.

Parameters:
- DATA_W, 64, table entry width; must match pqsdn_ram.
- ADDR_W, 10, table address width; table has 2**ADDR_W entries.
- TAG_W, 8, lookup tag width, returned unchanged with the response.
- RSP_DEPTH, 4, response FIFO entries (power of 2, >=2).
- CLR_ON_RST, 1, 1 = run a full clear after reset release.

Ports:
- clk  in  1  clock, shared with pqsdn_ram
- rst  in  1  asynchronous, active-high reset
- clr_start_i  in  1  pulse: start table clear
- clr_busy_o  out  1  clear in progress (CLEAR or DRAIN)
- clr_done_o  out  1  one-cycle pulse when clear completes
- upd_valid_i / upd_ready_o  in/out  1  update handshake
- upd_addr_i  in  ADDR_W  update address
- upd_data_i  in  DATA_W  update data
- lkp_valid_i / lkp_ready_o  in/out  1  lookup handshake
- lkp_addr_i  in  ADDR_W  lookup address
- lkp_tag_i  in  TAG_W  lookup tag
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake
- rsp_data_o  out  DATA_W  entry value
- rsp_tag_o  out  TAG_W  tag of the lookup
- ram_en_o, ram_wraddr_o, ram_wrdata_o  out  1/ADDR_W/DATA_W  to pqsdn_ram port A
- ram_rden_o, ram_rdaddr_o  out  1/ADDR_W  to pqsdn_ram port B
- ram_rddata_i  in  DATA_W  from pqsdn_ram

Behaviour:
- Reset state: FSM INIT, FIFO empty, forward registers invalid, inflight=0. All outputs 0.
- FSM:
  - INIT -> CLEAR if CLR_ON_RST, else IDLE.
  - IDLE -> CLEAR on clr_start_i.
  - CLEAR: one zero-write per cycle, address counter 0..2**ADDR_W-1; after the last address -> DRAIN.
  - DRAIN: 2 cycles, then -> IDLE with clr_done_o=1 for one cycle.
  - clr_start_i outside IDLE is ignored.
- clr_busy_o=1 in CLEAR and DRAIN. While busy, upd_ready_o=0 and lkp_ready_o=0. Already-issued lookups still complete and drain to rsp.
- Update path: upd_ready_o = !clr_busy_o. On upd fire: ram_en_o=1, ram_wraddr_o=upd_addr_i, ram_wrdata_o=upd_data_i, combinationally in the same cycle. In CLEAR, the RAM port carries the counter address with zero data.
- RAM timing is fixed: a write presented at edge E is visible to a read sampled at edge E+2 or later. A read sampled at edge E returns data in the cycle after E and holds it while ram_rden_o=0.
- Forwarding:
  - Keep fwd0 = RAM write presented this cycle and fwd1 = RAM write presented last cycle (valid, addr, data); both include clear writes.
  - At lookup issue, compare lkp_addr_i: a fwd0 match wins, else a fwd1 match, else RAM data.
  - The selection and forwarded data are registered alongside the tag for one cycle.
  - A same-cycle update and lookup to the same address returns the NEW data.
- Lookup path:
  - lkp_ready_o = !clr_busy_o && (fifo_count + inflight) < RSP_DEPTH.
  - On fire: ram_rden_o=1, ram_rdaddr_o=lkp_addr_i (combinational), and inflight<=1.
  - The next cycle pushes {muxed data, tag} into the FIFO.
  - Minimum latency: lkp fire at edge E gives rsp_valid_o=1 after edge E+1.
  - Throughput is 1 lookup/cycle while rsp_ready_i=1.
- Response FIFO is first-word fall-through. Pop on rsp_valid_o & rsp_ready_i. Push and pop in the same cycle are allowed when full. Overflow is impossible by credit.
- Response order equals lookup acceptance order.
- Reset mid-clear or with data in flight: everything is abandoned, return to INIT, and the clear restarts from address 0.

Decomposition:
- Package pqsdn_tbl_pkg holds:
  - FSM state encoding (INIT, IDLE, CLEAR, DRAIN).
  - RAM_WR_LAT=2.
  - DRAIN_CYC=2.
  - FWD_DEPTH=2.
- One sub-module: pqsdn_rsp_fifo, a parameterised FWFT sync FIFO (width DATA_W+TAG_W, depth RSP_DEPTH) with async active-high reset.

Test Plan:
- Reset release with CLR_ON_RST=1, ADDR_W=4:
  - clr_busy_o high for 16+2 cycles, with 16 zero-writes to addresses 0..15.
  - clr_done_o pulses once.
  - lkp_ready_o=0 throughout, then lookups of all addresses return 0.
- Update addr 5 = 0xA5 and lookup addr 5 in the same cycle -> rsp_data_o=0xA5.
  - Repeat with the lookup 1 cycle after the update -> 0xA5.
  - Repeat with 2 cycles after -> 0xA5 (from RAM).
- Back-to-back updates to addr 3 (0x11 then 0x22), then an immediate lookup of 3 -> 0x22, since fwd0 has priority over fwd1.
- Hold rsp_ready_i=0 and offer 6 lookups:
  - Exactly RSP_DEPTH=4 are accepted and lkp_ready_o drops.
  - Releasing rsp_ready_i returns tags in order, with no loss or duplicate.
- clr_start_i while a lookup is in flight -> that response still delivered with pre-clear data. Lookups issued after clr_done_o return 0.
- Assert rst mid-CLEAR (counter=7) -> outputs 0 immediately; after release the clear restarts at address 0.
